// File: rtl/prd_freq_div_amisha_pkg.sv
// Shared constants and state encoding for the period-to-frequency divider.
package prd_freq_pkg_amisha;

  localparam int unsigned DEF_DVND   = 1_000_000;
  localparam int unsigned DEF_DVND_W = 20;
  localparam int unsigned DEF_PRD_W  = 10;
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_DVND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/prd_freq_div_amisha_step.sv
// One restoring-division step: shift in the next dividend bit, compare, subtract.
module div_step_amisha #(
  parameter int unsigned PRD_W = 10
) (
  input  logic [PRD_W:0]   rem_in,
  input  logic             bit_in,
  input  logic [PRD_W-1:0] divisor,
  output logic [PRD_W:0]   rem_out,
  output logic             q_bit
);

  // rem_in is always below divisor, so its MSB is zero and this wider shift
  // yields the same result as a PRD_W+1 bit working value.
  logic [PRD_W+1:0] tmp;
  logic [PRD_W+1:0] diff;

  assign tmp     = {rem_in, bit_in};
  assign diff    = tmp - {2'b00, divisor};
  assign q_bit   = (tmp >= {2'b00, divisor});
  assign rem_out = q_bit ? diff[PRD_W:0] : tmp[PRD_W:0];

endmodule

// File: rtl/prd_freq_div_amisha.sv
// Frequency = DVND / period via a bit-serial restoring divider.
// Optional `ROUND_EN: round the final quotient to nearest instead of truncating.
module prd_freq_div_amisha
  import prd_freq_pkg_amisha::*;
#(
  parameter int unsigned DVND   = DEF_DVND,
  parameter int unsigned DVND_W = DEF_DVND_W,
  parameter int unsigned PRD_W  = DEF_PRD_W
) (
  input  logic              clk_amisha,
  input  logic              reset_amisha,
  input  logic              start_amisha,
  input  logic [PRD_W-1:0]  prd_in_amisha,
  output logic              ready_amisha,
  output logic              done_tick_amisha,
  output logic [DVND_W-1:0] freq_amisha,
  output logic              err_amisha
);

  localparam int unsigned       ITER_W    = $clog2(DVND_W + 1);
  localparam logic [DVND_W-1:0] DVND_VAL  = DVND_W'(DVND);
  localparam logic [ITER_W-1:0] ITER_INIT = ITER_W'(DVND_W);

  state_e              state_q, state_d;
  logic [PRD_W-1:0]    divisor_q, divisor_d;
  logic [DVND_W-1:0]   quo_q, quo_d;
  logic [PRD_W:0]      rem_q, rem_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [DVND_W-1:0]   freq_q, freq_d;
  logic                err_q, err_d;

  logic [PRD_W:0]      step_rem;
  logic                step_bit;

  div_step_amisha #(.PRD_W(PRD_W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[DVND_W-1]),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

`ifdef ROUND_EN
  logic round_up;
  assign round_up = ({step_rem, 1'b0} >= {2'b00, divisor_q});
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    freq_d    = freq_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start_amisha) begin
          divisor_d = prd_in_amisha;
          quo_d     = DVND_VAL;
          rem_d     = '0;
          cnt_d     = ITER_INIT;
          if (prd_in_amisha == '0) begin
            state_d = DONE;
            freq_d  = '1;
            err_d   = 1'b1;
          end else begin
            state_d = OP;
          end
        end
      end
      OP: begin
        rem_d = step_rem;
        quo_d = {quo_q[DVND_W-2:0], step_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == ITER_W'(1)) begin
          state_d = DONE;
          err_d   = 1'b0;
`ifdef ROUND_EN
          freq_d  = quo_d + DVND_W'(round_up);
`else
          freq_d  = quo_d;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      freq_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      freq_q    <= freq_d;
      err_q     <= err_d;
    end
  end

  assign ready_amisha     = (state_q == IDLE);
  assign done_tick_amisha = (state_q == DONE);
  assign freq_amisha      = freq_q;
  assign err_amisha       = err_q;

endmodule

// File: tb/tb_prd_freq_div_amisha.sv
// Self-checking bench: directed and random periods against an arithmetic reference.
module tb_prd_freq_div_amisha;

  localparam int unsigned DVND = 1_000_000;

  logic        clk_amisha = 1'b0;
  logic        reset_amisha;
  logic        start_amisha;
  logic [9:0]  prd_in_amisha;
  logic        ready_amisha;
  logic        done_tick_amisha;
  logic [19:0] freq_amisha;
  logic        err_amisha;

  int n_checks = 0;
  int n_errors = 0;

  prd_freq_div_amisha dut (
    .clk_amisha       (clk_amisha),
    .reset_amisha     (reset_amisha),
    .start_amisha     (start_amisha),
    .prd_in_amisha    (prd_in_amisha),
    .ready_amisha     (ready_amisha),
    .done_tick_amisha (done_tick_amisha),
    .freq_amisha      (freq_amisha),
    .err_amisha       (err_amisha)
  );

  always #5 clk_amisha = ~clk_amisha;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input int unsigned p, output logic [19:0] f, output logic e);
    int unsigned q;
    int unsigned r;
    if (p == 0) begin
      f = 20'hFFFFF;
      e = 1'b1;
    end else begin
      q = DVND / p;
      r = DVND % p;
`ifdef ROUND_EN
      if (2 * r >= p) q++;
`endif
      f = 20'(q);
      e = 1'b0;
    end
  endfunction

  // Runs one operation. repulse: fire a second start (prd=7) mid-operation.
  // hold_in_done: keep start high during the done cycle; it must be ignored.
  task automatic run_op(input logic [9:0] p, input bit repulse, input bit hold_in_done);
    logic [19:0] ef;
    logic        ee;
    int          exp_lat;
    int          lat;
    int          ready_low;
    int          dones;
    ref_div(p, ef, ee);
    exp_lat   = (p == 0) ? 1 : 21;
    lat       = 0;
    ready_low = 0;
    dones     = 0;
    @(negedge clk_amisha);
    start_amisha  = 1'b1;
    prd_in_amisha = p;
    @(negedge clk_amisha);
    start_amisha  = 1'b0;
    prd_in_amisha = 10'($urandom);
    for (int n = 1; n <= exp_lat + 3; n++) begin
      if (n > 1) @(negedge clk_amisha);
      if (!ready_amisha) ready_low++;
      if (n == exp_lat + 1) begin
        check($sformatf("ready_after_p%0d", p), 32'(ready_amisha), 32'd1);
        start_amisha = 1'b0;
      end
      if (done_tick_amisha) begin
        dones++;
        if (lat == 0) begin
          lat = n;
          check($sformatf("freq_p%0d", p), 32'(freq_amisha), 32'(ef));
          check($sformatf("err_p%0d", p), 32'(err_amisha), 32'(ee));
        end
        if (hold_in_done) begin
          start_amisha  = 1'b1;
          prd_in_amisha = 10'd5;
        end
      end
      if (repulse && n == 5) begin
        start_amisha  = 1'b1;
        prd_in_amisha = 10'd7;
      end
      if (repulse && n == 6) start_amisha = 1'b0;
    end
    check($sformatf("latency_p%0d", p), 32'(lat), 32'(exp_lat));
    check($sformatf("ready_low_p%0d", p), 32'(ready_low), 32'(exp_lat));
    check($sformatf("done_count_p%0d", p), 32'(dones), 32'd1);
    check($sformatf("freq_held_p%0d", p), 32'(freq_amisha), 32'(ef));
  endtask

  initial begin
    int rand_p;
    int spurious;
    reset_amisha  = 1'b1;
    start_amisha  = 1'b0;
    prd_in_amisha = '0;
    repeat (3) @(negedge clk_amisha);
    check("rst_ready", 32'(ready_amisha), 32'd1);
    check("rst_done", 32'(done_tick_amisha), 32'd0);
    check("rst_freq", 32'(freq_amisha), 32'd0);
    check("rst_err", 32'(err_amisha), 32'd0);
    reset_amisha = 1'b0;

    run_op(10'd4, 1'b0, 1'b0);
    run_op(10'd6, 1'b0, 1'b0);
    run_op(10'd3, 1'b0, 1'b0);
    run_op(10'd1023, 1'b0, 1'b0);
    run_op(10'd1, 1'b0, 1'b0);
    run_op(10'd0, 1'b0, 1'b0);
    run_op(10'd4, 1'b0, 1'b0);
    run_op(10'd9, 1'b1, 1'b0);
    run_op(10'd11, 1'b0, 1'b1);
    run_op(10'd0, 1'b0, 1'b1);

    // Abort mid-operation: reset clears everything at once, no done_tick follows.
    @(negedge clk_amisha);
    start_amisha  = 1'b1;
    prd_in_amisha = 10'd4;
    @(negedge clk_amisha);
    start_amisha = 1'b0;
    repeat (9) @(negedge clk_amisha);
    reset_amisha = 1'b1;
    #1;
    check("abort_ready", 32'(ready_amisha), 32'd1);
    check("abort_done", 32'(done_tick_amisha), 32'd0);
    check("abort_freq", 32'(freq_amisha), 32'd0);
    check("abort_err", 32'(err_amisha), 32'd0);
    @(negedge clk_amisha);
    reset_amisha = 1'b0;
    spurious = 0;
    repeat (25) begin
      @(negedge clk_amisha);
      if (done_tick_amisha) spurious++;
    end
    check("abort_no_done", 32'(spurious), 32'd0);
    run_op(10'd7, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rand_p = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 1023));
      run_op(10'(rand_p), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
